// File: rtl/qif_neuron_scheduler.sv
// Time-multiplexed QIF neuron scheduler: owns per-neuron V/I state, sequences one
// shared datapath update per neuron per tick, and emits spike events via ready/valid.
module qif_neuron_scheduler #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_sel,
    input  logic [AW-1:0] cfg_addr,
    input  logic [W-1:0]  cfg_data,
    output logic          dp_start,
    output logic [W-1:0]  dp_v,
    output logic [W-1:0]  dp_i,
    input  logic          dp_done,
    input  logic [W-1:0]  dp_v_next,
    output logic          spike_valid,
    output logic [AW-1:0] spike_id,
    input  logic          spike_ready,
    output logic          busy,
    output logic          round_done,
    output logic          overrun
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SPIKE, DONE} state_t;

    state_t        state, state_next;
    logic [AW-1:0] idx, idx_next;
    logic [W-1:0]  v_mem [N];
    logic [W-1:0]  i_mem [N];
    logic [W-1:0]  v_th, v_reset;
    logic [W-1:0]  op_v, op_i;
    logic          last, fire, wb_en;
    logic [W-1:0]  wb_val;

    assign last     = (idx == AW'(N - 1));
    assign fire     = $signed(dp_v_next) >= $signed(v_th);
    assign busy     = (state != IDLE);
    assign spike_id = spike_valid ? idx : '0;

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        wb_en       = 1'b0;
        wb_val      = dp_v_next;
        dp_start    = 1'b0;
        dp_v        = '0;
        dp_i        = '0;
        spike_valid = 1'b0;
        round_done  = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_next = ISSUE;
                    idx_next   = '0;
                end
            end
            ISSUE: begin
                // Operands come straight from state here and from the latched copy in WAIT,
                // so an I write during WAIT cannot disturb the in-flight request.
                dp_start   = 1'b1;
                dp_v       = v_mem[idx];
                dp_i       = i_mem[idx];
                state_next = WAIT;
            end
            WAIT: begin
                dp_v = op_v;
                dp_i = op_i;
                if (dp_done) begin
                    wb_en = 1'b1;
                    if (fire) begin
                        wb_val     = v_reset;
                        state_next = SPIKE;
                    end else if (last) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx + AW'(1);
                        state_next = ISSUE;
                    end
                end
            end
            SPIKE: begin
                spike_valid = 1'b1;
                if (spike_ready) begin
                    if (last) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx + AW'(1);
                        state_next = ISSUE;
                    end
                end
            end
            DONE: begin
                round_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            overrun <= 1'b0;
            op_v    <= '0;
            op_i    <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (tick && busy) overrun <= 1'b1;
            if (state == ISSUE) begin
                op_v <= v_mem[idx];
                op_i <= i_mem[idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < N; k++) begin
                v_mem[k] <= '0;
                i_mem[k] <= '0;
            end
            v_th    <= W'(64);
            v_reset <= W'(-32);
        end else begin
            if (cfg_we && cfg_sel == 2'd0) i_mem[cfg_addr] <= cfg_data;
            // V writes and datapath writeback never collide: the former is IDLE-only.
            if (cfg_we && cfg_sel == 2'd1 && state == IDLE) v_mem[cfg_addr] <= cfg_data;
            if (wb_en) v_mem[idx] <= wb_val;
            if (cfg_we && cfg_sel == 2'd2) v_th <= cfg_data;
            if (cfg_we && cfg_sel == 2'd3) v_reset <= cfg_data;
        end
    end

endmodule

// File: doc/qif_neuron_scheduler.md
# qif_neuron_scheduler

Time-multiplexes one shared QIF membrane-update datapath across `N` virtual neurons inside `tt_um_QIFNeuron`. Holds per-neuron membrane voltage and input current, sequences one update per neuron per `tick`, detects threshold crossings, applies the post-spike reset and emits spike events over a ready/valid port. It is the only master of the datapath and the only writer of neuron state.

## Interface
- `N`, default 4: number of virtual neurons, a power of two from 2 to 16.
- `W`, default 8: membrane, current and threshold width (signed two's complement).
- `clk` in 1: the single clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `tick` in 1: start one update round. Level-sampled in IDLE.
- `cfg_we` in 1: configuration write strobe.
- `cfg_sel` in 2: 0 = I[addr], 1 = V[addr], 2 = v_th, 3 = v_reset.
- `cfg_addr` in log2(N): neuron index.
- `cfg_data` in W: write data.
- `dp_start` out 1: one-cycle request to the datapath.
- `dp_v` out W, `dp_i` out W: operands, held stable from `dp_start` until `dp_done`.
- `dp_done` in 1: datapath result valid (latency ≥1 cycle after `dp_start`).
- `dp_v_next` in W: updated membrane voltage, valid with `dp_done`.
- `spike_valid` out 1, `spike_id` out log2(N), `spike_ready` in 1: spike event handshake.
- `busy` out 1: high in any state other than IDLE.
- `round_done` out 1: one-cycle pulse when a round completes.
- `overrun` out 1: sticky; set when `tick`=1 while `busy`=1. Cleared only by reset.

## Operation
- State arrays: V[0..N-1], I[0..N-1], plus scalars v_th and v_reset, all registered.
- Reset values: V=0, I=0, v_th=+64 (0x40), v_reset=−32 (0xE0). All outputs 0. FSM in IDLE, idx=0.
- FSM states: IDLE, ISSUE, WAIT, SPIKE, DONE.
  - IDLE: `tick`=1 → ISSUE, idx←0.
  - ISSUE: `dp_start`=1 for exactly one cycle, with `dp_v`=V[idx] and `dp_i`=I[idx] → WAIT.
  - WAIT: hold the operands. On `dp_done`=1, compare signed `dp_v_next` ≥ v_th.
    - Spike: V[idx]←v_reset → SPIKE.
    - No spike: V[idx]←`dp_v_next`. If idx=N−1 → DONE, else idx←idx+1 → ISSUE.
  - SPIKE: `spike_valid`=1, `spike_id`=idx, held stable until `spike_ready`=1 is sampled. Then → DONE if idx=N−1, else idx←idx+1 → ISSUE.
  - DONE: `round_done`=1 for one cycle → IDLE.
- A `dp_done` outside WAIT is ignored.
- Configuration writes:
  - I, v_th and v_reset writes take effect on the next clock edge, in any state.
  - A neuron's I is read at its ISSUE, so a mid-round write affects that neuron only if it lands before its ISSUE cycle.
  - V writes apply only in IDLE; V writes while `busy` are dropped.
- Comparison is signed W-bit, with no saturation in this block. The datapath owns clamping.
- `tick` while `busy`: ignored, and sets `overrun`. No queued round.

## Timing
- Zero-latency datapath is not supported: `dp_done` is ignored in the ISSUE cycle.
- Round length with datapath latency L and no backpressure: 1 (IDLE→ISSUE) + N·(1+L) + 1 (DONE) cycles. Each spike adds ≥1 cycle.
- V writeback is visible on `dp_v` at that neuron's next ISSUE.
- Simultaneous `cfg_we` to v_th and a WAIT-state compare in the same cycle: the compare uses the old v_th.
- `spike_valid` and `spike_ready` high in the same cycle is the accept. The earliest next `dp_start` is the following cycle.
- Reset asserted mid-round: immediate return to IDLE and reset values. Outputs drop asynchronously. A late `dp_done` after reset is ignored.

## Test plan
Bench datapath model: `dp_v_next` = `dp_v` + `dp_i`, L=2.
- Reset check: reset values, then `tick` with I=0 → four `dp_start` pulses with `dp_v`=0, no spike, `round_done` at cycle 14, V unchanged.
- Spike: I[2]=40, V[2]=30 → one `spike_valid` with `spike_id`=2. V[2] reads −32 at the next round's ISSUE. Other neurons stay at 0.
- Backpressure: spike on neuron 1 with `spike_ready` held low 5 cycles → `spike_valid` and `spike_id`=1 stable, no `dp_start` for neuron 2 until the accept, round extended by 5 cycles.
- Overrun and dropped writes: `tick` during round → `overrun`=1 and stays set, no extra round. V write while `busy` is dropped. The same write in IDLE sticks.
- Signed boundary: v_th=−1, V[0]=−2, I[0]=+1 → spike. With v_th=+127, V=127, I=0 → spike. With V=126, I=0 → no spike.
- Reset mid-WAIT: assert `rst` while awaiting `dp_done` → IDLE, all state at reset values, a subsequent `dp_done` causes no writeback.
